prime_div_classifier: RTL and testbench

- Parametrised, sequential successor to the 4-bit prime / divisible-by-3 combinational classifier.
- Accepts one WIDTH-bit unsigned value per valid/ready handshake and runs a single shared bit-serial remainder unit.
- First pass tests divisibility by DIV (d); following passes do trial division for primality (p).
- Result is returned on a valid/ready output port; it sits between a number source and any downstream consumer that can stall.

---
 rtl/prime_div_classifier.sv | 140 ++++++++++++++
 tb/tb_prime_div_classifier.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/prime_div_classifier.sv
// Sequential prime / divisible-by-DIV classifier.
// One shared bit-serial remainder unit runs one MSB-first pass of WIDTH cycles per divisor.
// The first pass divides by DIV to produce d. Each later pass divides by a trial divisor
// t = 2, 3, ... to decide p.
module prime_div_classifier #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             p,
  output logic             d
);

  localparam int unsigned IdxW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0]  IdxTop = IdxW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DivW   = WIDTH'(DIV);

  typedef enum logic [1:0] {StIdle, StModk, StTrial, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] t_q;
  logic [IdxW-1:0]  idx_q;
  logic             p_q, d_q, out_valid_q;

  logic [WIDTH-1:0]   divisor;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH:0]     t_p1;
  logic [2*WIDTH+1:0] t_sq;
  logic               last_bit;
  logic               sq_exceeds;

  // One remainder step. The remainder is below the divisor, so a single subtract suffices.
  always_comb begin
    divisor    = (state_q == StModk) ? DivW : t_q;
    shifted    = {rem_q, val_q[idx_q]};
    rem_next   = '0;
    if (shifted >= {1'b0, divisor}) begin
      rem_next = WIDTH'(shifted - {1'b0, divisor});
    end else begin
      rem_next = shifted[WIDTH-1:0];
    end
    last_bit   = (idx_q == '0);
    t_p1       = {1'b0, t_q} + {{WIDTH{1'b0}}, 1'b1};
    t_sq       = {{(WIDTH+1){1'b0}}, t_p1} * {{(WIDTH+1){1'b0}}, t_p1};
    sq_exceeds = t_sq > {{(WIDTH+2){1'b0}}, val_q};
  end

  // Accept is only possible in IDLE, and is blocked while reset is high.
  always_comb begin
    in_ready = (state_q == StIdle) && !reset;
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign d         = d_q;

  // Control FSM and datapath registers. A reset aborts any pass in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      val_q       <= '0;
      rem_q       <= '0;
      t_q         <= '0;
      idx_q       <= '0;
      p_q         <= 1'b0;
      d_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            val_q   <= a;
            rem_q   <= '0;
            idx_q   <= IdxTop;
            state_q <= StModk;
          end
        end
        StModk: begin
          if (last_bit) begin
            d_q <= (rem_next == '0);
            if ((val_q >> 1) == '0) begin
              p_q         <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else if ((val_q >> 2) == '0) begin
              p_q         <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              t_q     <= WIDTH'(2);
              rem_q   <= '0;
              idx_q   <= IdxTop;
              state_q <= StTrial;
            end
          end else begin
            rem_q <= rem_next;
            idx_q <= idx_q - 1'b1;
          end
        end
        StTrial: begin
          if (last_bit) begin
            if (rem_next == '0) begin
              p_q         <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else if (sq_exceeds) begin
              p_q         <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              t_q   <= t_p1[WIDTH-1:0];
              rem_q <= '0;
              idx_q <= IdxTop;
            end
          end else begin
            rem_q <= rem_next;
            idx_q <= idx_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_div_classifier.sv
// Scoreboard bench for prime_div_classifier.
// It drives two instances: WIDTH=4/DIV=3 and WIDTH=8/DIV=5.
module tb_prime_div_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int   a;
    logic p;
    logic d;
    int   lat;
    int   acc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  logic       rst4, in_valid4, in_ready4, out_valid4, out_ready4, p4, d4;
  logic [3:0] a4;
  logic       rst8, in_valid8, in_ready8, out_valid8, out_ready8, p8, d8;
  logic [7:0] a8;

  prime_div_classifier #(.WIDTH(4), .DIV(3)) u_dut4 (
    .clk(clk), .reset(rst4), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4),
    .out_valid(out_valid4), .out_ready(out_ready4), .p(p4), .d(d4)
  );

  prime_div_classifier #(.WIDTH(8), .DIV(5)) u_dut8 (
    .clk(clk), .reset(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8),
    .out_valid(out_valid8), .out_ready(out_ready8), .p(p8), .d(d8)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor for the 4-bit instance: latency on the first out_valid cycle, p/d on handshake.
  bit seen4 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid4 && !seen4) begin
      seen4 = 1;
      if (q4.size() == 0) check("w4 unexpected out_valid", 1, 0);
      else check($sformatf("w4 latency a=%0d", q4[0].a), cyc - q4[0].acc, q4[0].lat);
    end
    if (out_valid4 && out_ready4) begin
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check($sformatf("w4 p a=%0d", e.a), int'(p4), int'(e.p));
        check($sformatf("w4 d a=%0d", e.a), int'(d4), int'(e.d));
      end
      seen4 = 0;
    end
  end

  // Monitor for the 8-bit instance.
  bit seen8 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid8 && !seen8) begin
      seen8 = 1;
      if (q8.size() == 0) check("w8 unexpected out_valid", 1, 0);
      else check($sformatf("w8 latency a=%0d", q8[0].a), cyc - q8[0].acc, q8[0].lat);
    end
    if (out_valid8 && out_ready8) begin
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check($sformatf("w8 p a=%0d", e.a), int'(p8), int'(e.p));
        check($sformatf("w8 d a=%0d", e.a), int'(d8), int'(e.d));
      end
      seen8 = 0;
    end
  end

  task automatic issue(input bit w8, input int v, input logic ep, input logic ed, input int lat);
    int n;
    exp_t e;
    @(posedge clk); #1;
    if (w8) begin a8 = v[7:0]; in_valid8 = 1'b1; end
    else    begin a4 = v[3:0]; in_valid4 = 1'b1; end
    n = 0;
    @(negedge clk);
    while (!(w8 ? in_ready8 : in_ready4) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!(w8 ? in_ready8 : in_ready4)) check("accept timeout", 0, 1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    e.a = v; e.p = ep; e.d = ed; e.lat = lat; e.acc = cyc;
    if (w8) q8.push_back(e);
    else    q4.push_back(e);
  endtask

  task automatic drain(input bit w8);
    int n;
    n = 0;
    while ((w8 ? q8.size() : q4.size()) > 0 && n < 400) begin
      n++;
      @(negedge clk);
    end
    if ((w8 ? q8.size() : q4.size()) > 0) begin
      check(w8 ? "w8 result timeout" : "w4 result timeout", 0, 1);
      if (w8) q8.delete();
      else    q4.delete();
    end
  endtask

  // Hand-computed results for a = 0..15 at WIDTH=4, DIV=3: {p, d, latency}.
  logic tab_p [16] = '{0,0,1,1,0,1,0,1,0,0,0,1,0,1,0,0};
  logic tab_d [16] = '{1,0,0,1,0,0,1,0,0,1,0,0,1,0,0,1};
  int   tab_l [16] = '{4,4,4,4,8,8,8,8,8,12,8,12,8,12,8,12};

  initial begin
    int n;
    rst4 = 1'b1; rst8 = 1'b1;
    in_valid4 = 1'b0; in_valid8 = 1'b0; a4 = '0; a8 = '0;
    out_ready4 = 1'b1; out_ready8 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("w4 in_ready in reset", int'(in_ready4), 0);
    check("w8 in_ready in reset", int'(in_ready8), 0);
    check("w4 out_valid in reset", int'(out_valid4), 0);
    check("w4 p in reset", int'(p4), 0);
    check("w4 d in reset", int'(d4), 0);
    check("w8 out_valid in reset", int'(out_valid8), 0);
    @(posedge clk); #1;
    rst4 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    check("w4 in_ready after reset", int'(in_ready4), 1);
    check("w8 in_ready after reset", int'(in_ready8), 1);

    // Exhaustive 4-bit sweep.
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, i, tab_p[i], tab_d[i], tab_l[i]);
      drain(1'b0);
    end

    // 8-bit directed values, DIV=5.
    issue(1'b1, 251, 1'b1, 1'b0, 120); drain(1'b1);
    issue(1'b1, 255, 1'b0, 1'b1, 24);  drain(1'b1);
    issue(1'b1, 2,   1'b1, 1'b0, 8);   drain(1'b1);

    // Backpressure: the result must hold while the consumer stalls and inputs wiggle.
    out_ready4 = 1'b0;
    issue(1'b0, 7, 1'b1, 1'b0, 8);
    n = 0;
    while (!out_valid4 && n < 50) begin n++; @(negedge clk); end
    check("w4 bp out_valid rises", int'(out_valid4), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid4 = ~in_valid4;
      a4 = 4'($urandom);
      @(negedge clk);
      check("w4 bp out_valid held", int'(out_valid4), 1);
      check("w4 bp p held", int'(p4), 1);
      check("w4 bp d held", int'(d4), 0);
      check("w4 bp in_ready low", int'(in_ready4), 0);
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(negedge clk);
    check("w4 in_ready low in handshake cycle", int'(in_ready4), 0);
    @(negedge clk);
    check("w4 out_valid low after handshake", int'(out_valid4), 0);
    check("w4 in_ready high after handshake", int'(in_ready4), 1);
    drain(1'b0);

    // Reset mid-operation: the pending result must never appear.
    issue(1'b1, 251, 1'b1, 1'b0, 120);
    repeat (29) @(posedge clk);
    #1;
    rst8 = 1'b1;
    q8.delete();
    @(negedge clk);
    check("w8 in_ready during mid-op reset", int'(in_ready8), 0);
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(negedge clk);
    check("w8 in_ready after mid-op reset", int'(in_ready8), 1);
    check("w8 out_valid after mid-op reset", int'(out_valid8), 0);
    repeat (130) @(negedge clk);
    // 9: MODK, t=2 (rem 1, 9 not < 9), t=3 (rem 0) -> three passes of 8 cycles.
    issue(1'b1, 9, 1'b0, 1'b0, 24); drain(1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
